id_inst_queue: RTL and testbench

//  Parametrised instruction queue between IF and the decode stage. Buffers {pc, inst, inslot} entries.

---
 rtl/id_inst_queue_pkg.sv | 34 +++
 rtl/iq_predecode.sv | 35 +++
 rtl/id_inst_queue.sv | 173 +++++++++++++++++
 tb/tb_id_inst_queue.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_inst_queue_pkg.sv
// Shared constants and entry layout for the IF->ID instruction queue.
package id_inst_queue_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  localparam int unsigned IQ_ENTRY_W = 65;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inslot;
  } iq_entry_t;

  // Pointer width including the wrap bit.
  function automatic int unsigned iq_ptr_w(input int unsigned depth);
    return unsigned'($clog2(depth) + 1);
  endfunction

endpackage

// File: rtl/iq_predecode.sv
// Branch/jump predecode of one fetched instruction; drives the delay-slot bit
// of the entry that follows it.
module iq_predecode
  import id_inst_queue_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic        is_branch_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign opcode        = inst_i[31:26];
  assign rt            = inst_i[20:16];
  assign rd            = inst_i[15:11];
  assign funct         = inst_i[5:0];
  assign unused_fields = ^{inst_i[25:21], inst_i[10:6]};

  always_comb begin
    is_branch_o = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE, OP_J, OP_JAL: is_branch_o = 1'b1;
      OP_BLEZ, OP_BGTZ:             is_branch_o = (rt == 5'd0);
      OP_REGIMM: is_branch_o = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                               (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
      OP_SPECIAL: is_branch_o = ((funct == FN_JR) && (rt == 5'd0) && (rd == 5'd0)) ||
                                ((funct == FN_JALR) && (rt == 5'd0));
      default: is_branch_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_inst_queue.sv
// Instruction queue between IF and decode: multi-lane push/pop circular buffer
// that tags delay-slot entries and trims younger entries on a taken branch.
module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PUSH_W = 2,
  parameter int unsigned POP_W  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         br_flush_i,
  input  logic [PUSH_W-1:0]            push_valid_i,
  input  logic [32*PUSH_W-1:0]         push_pc_i,
  input  logic [32*PUSH_W-1:0]         push_inst_i,
  output logic                         push_ready_o,
  output logic [POP_W-1:0]             pop_valid_o,
  output logic [32*POP_W-1:0]          pop_pc_o,
  output logic [32*POP_W-1:0]          pop_inst_o,
  output logic [POP_W-1:0]             pop_inslot_o,
  input  logic [$clog2(POP_W+1)-1:0]   pop_cnt_i,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned PTR_W = iq_ptr_w(DEPTH);
  localparam int unsigned IDX_W = PTR_W - 1;

  logic [IQ_ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             last_br_q, last_br_d;
  logic             wait_slot_q, wait_slot_d;

  logic [PUSH_W-1:0] lane_br;
  logic [PUSH_W-1:0] we;
  iq_entry_t         wdata [PUSH_W];
  logic [IDX_W-1:0]  waddr [PUSH_W];
  iq_entry_t         rd_ent [POP_W];

  logic [PTR_W-1:0] push_avail;
  logic [PTR_W-1:0] push_n;
  logic [PTR_W-1:0] pop_req;
  logic [PTR_W-1:0] pop_n;
  logic             can_push;
  logic             prev_br;

  for (genvar k = 0; k < PUSH_W; k++) begin : g_pdec
    iq_predecode u_pdec (
      .inst_i      (push_inst_i[32*k +: 32]),
      .is_branch_o (lane_br[k])
    );
  end

  // Ready depends only on current occupancy, never on the same-cycle pop.
  assign can_push = (PTR_W'(DEPTH) - count_q) >= PTR_W'(PUSH_W);
  assign push_n   = can_push ? push_avail : '0;
  assign pop_req  = PTR_W'(pop_cnt_i);
  assign pop_n    = (pop_req > count_q) ? count_q : pop_req;

  // Valid lanes are contiguous from lane 0; count the leading run.
  always_comb begin
    push_avail = '0;
    for (int k = 0; k < PUSH_W; k++) begin
      if (push_valid_i[k] && (push_avail == PTR_W'(k))) begin
        push_avail = push_avail + PTR_W'(1);
      end
    end
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    last_br_d   = last_br_q;
    wait_slot_d = wait_slot_q;
    we          = '0;
    prev_br     = last_br_q;
    for (int k = 0; k < PUSH_W; k++) begin
      wdata[k].pc     = push_pc_i[32*k +: 32];
      wdata[k].inst   = push_inst_i[32*k +: 32];
      wdata[k].inslot = prev_br;
      prev_br         = lane_br[k];
      waddr[k]        = tail_q[IDX_W-1:0] + IDX_W'(k);
    end

    if (flush_i) begin
      head_d      = tail_q;
      count_d     = '0;
      last_br_d   = 1'b0;
      wait_slot_d = 1'b0;
    end else if (br_flush_i && (pop_n != '0)) begin
      head_d      = head_q + pop_n;
      last_br_d   = 1'b0;
      wait_slot_d = 1'b0;
      if (count_q > pop_n) begin
        // Keep only the delay slot right behind the popped branch.
        tail_d  = head_q + pop_n + PTR_W'(1);
        count_d = PTR_W'(1);
      end else if (push_n != '0) begin
        we[0]           = 1'b1;
        wdata[0].inslot = 1'b1;
        tail_d          = tail_q + PTR_W'(1);
        count_d         = PTR_W'(1);
      end else begin
        count_d     = '0;
        wait_slot_d = 1'b1;
      end
    end else begin
      head_d = head_q + pop_n;
      if (wait_slot_q) begin
        count_d = count_q - pop_n;
        if (push_n != '0) begin
          we[0]           = 1'b1;
          wdata[0].inslot = 1'b1;
          tail_d          = tail_q + PTR_W'(1);
          count_d         = count_q - pop_n + PTR_W'(1);
          wait_slot_d     = 1'b0;
          last_br_d       = 1'b0;
        end
      end else begin
        for (int k = 0; k < PUSH_W; k++) begin
          we[k] = PTR_W'(k) < push_n;
          if (PTR_W'(k + 1) == push_n) begin
            last_br_d = lane_br[k];
          end
        end
        tail_d  = tail_q + push_n;
        count_d = count_q - pop_n + push_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      last_br_q   <= 1'b0;
      wait_slot_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      last_br_q   <= last_br_d;
      wait_slot_q <= wait_slot_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < PUSH_W; k++) begin
      if (we[k]) begin
        mem_q[waddr[k]] <= wdata[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < POP_W; k++) begin
      rd_ent[k]              = mem_q[head_q[IDX_W-1:0] + IDX_W'(k)];
      pop_pc_o[32*k +: 32]   = rd_ent[k].pc;
      pop_inst_o[32*k +: 32] = rd_ent[k].inst;
      pop_inslot_o[k]        = rd_ent[k].inslot;
      pop_valid_o[k]         = !rst && (count_q > PTR_W'(k));
    end
  end

  assign push_ready_o = can_push && !rst;
  assign count_o      = rst ? '0 : count_q;

endmodule

// File: tb/tb_id_inst_queue.sv
// Self-checking bench for id_inst_queue: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_id_inst_queue;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned PUSH_W = 2;
  localparam int unsigned POP_W  = 2;
  localparam int unsigned PCW    = $clog2(POP_W + 1);
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  localparam logic [31:0] I_ADDU = 32'h0043_0821;
  localparam logic [31:0] I_BEQ  = 32'h1043_0004;
  localparam logic [31:0] I_J    = 32'h0800_0040;
  localparam logic [31:0] I_JAL  = 32'h0C00_0040;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  br_flush;
  logic [PUSH_W-1:0]     push_valid;
  logic [32*PUSH_W-1:0]  push_pc;
  logic [32*PUSH_W-1:0]  push_inst;
  logic                  push_ready;
  logic [POP_W-1:0]      pop_valid;
  logic [32*POP_W-1:0]   pop_pc;
  logic [32*POP_W-1:0]   pop_inst;
  logic [POP_W-1:0]      pop_inslot;
  logic [PCW-1:0]        pop_cnt;
  logic [CW-1:0]         count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inslot;
  } m_ent_t;

  m_ent_t mq[$];
  bit     m_last_br;
  bit     m_wait;

  always #5 clk = ~clk;

  id_inst_queue #(.DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .br_flush_i   (br_flush),
    .push_valid_i (push_valid),
    .push_pc_i    (push_pc),
    .push_inst_i  (push_inst),
    .push_ready_o (push_ready),
    .pop_valid_o  (pop_valid),
    .pop_pc_o     (pop_pc),
    .pop_inst_o   (pop_inst),
    .pop_inslot_o (pop_inslot),
    .pop_cnt_i    (pop_cnt),
    .count_o      (count)
  );

  // Branch classification straight from the ISA list of control transfers.
  function automatic bit m_is_br(input logic [31:0] i);
    logic [5:0] op;
    logic [4:0] rt;
    op = i[31:26];
    rt = i[20:16];
    if (op == 6'd4 || op == 6'd5 || op == 6'd2 || op == 6'd3) return 1'b1;
    if (op == 6'd6 || op == 6'd7) return rt == 5'd0;
    if (op == 6'd1) return (rt == 5'd0 || rt == 5'd1 || rt == 5'd16 || rt == 5'd17);
    if (op == 6'd0) return (i[5:0] == 6'd8 && i[20:11] == 10'd0) ||
                           (i[5:0] == 6'd9 && rt == 5'd0);
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_inst();
    case ($urandom_range(0, 11))
      0:  return I_BEQ;
      1:  return 32'h1443_0004;
      2:  return 32'h1840_0004;
      3:  return 32'h1C41_0004;
      4:  return 32'h0450_0004;
      5:  return 32'h0442_0004;
      6:  return I_J;
      7:  return I_JAL;
      8:  return 32'h03E0_0008;
      9:  return 32'h0040_F809;
      10: return I_ADDU;
      default: return $urandom;
    endcase
  endfunction

  // Reference update for one clock edge using the currently driven inputs.
  task automatic model_step();
    int     sz, n, p;
    bit     rdy;
    m_ent_t e;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      m_last_br = 1'b0;
      m_wait    = 1'b0;
      return;
    end
    rdy = (DEPTH - sz) >= PUSH_W;
    n = 0;
    if (rdy) begin
      for (int k = 0; k < PUSH_W; k++) if (push_valid[k] && n == k) n++;
    end
    p = (int'(pop_cnt) < sz) ? int'(pop_cnt) : sz;
    if (flush) begin
      mq.delete();
      m_last_br = 1'b0;
      m_wait    = 1'b0;
    end else if (br_flush && p >= 1) begin
      m_last_br = 1'b0;
      m_wait    = 1'b0;
      if (sz > p) begin
        e = mq[p];
        mq.delete();
        mq.push_back(e);
      end else begin
        mq.delete();
        if (n >= 1) mq.push_back('{push_pc[31:0], push_inst[31:0], 1'b1});
        else        m_wait = 1'b1;
      end
    end else begin
      repeat (p) void'(mq.pop_front());
      if (m_wait) begin
        if (n >= 1) begin
          mq.push_back('{push_pc[31:0], push_inst[31:0], 1'b1});
          m_wait    = 1'b0;
          m_last_br = 1'b0;
        end
      end else begin
        for (int k = 0; k < n; k++) begin
          e.pc     = push_pc[32*k +: 32];
          e.inst   = push_inst[32*k +: 32];
          e.inslot = (k == 0) ? m_last_br : m_is_br(push_inst[32*(k-1) +: 32]);
          mq.push_back(e);
        end
        if (n > 0) m_last_br = m_is_br(push_inst[32*(n-1) +: 32]);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit f, input bit b, input logic [1:0] pv,
                       input logic [31:0] pc0, input logic [31:0] i0,
                       input logic [31:0] pc1, input logic [31:0] i1, input int pc);
    flush      = f;
    br_flush   = b;
    push_valid = pv;
    push_pc    = {pc1, pc0};
    push_inst  = {i1, i0};
    pop_cnt    = PCW'(pc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 2'b11, 32'h10, I_ADDU, 32'h14, I_ADDU, 0);
    tick();
    tick();
    n_checks++; if (push_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready: got %b want 0", push_ready); end
    n_checks++; if (pop_valid !== 2'b00) begin n_errors++; $display("FAIL rst_valid: got %b want 00", pop_valid); end
    n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL rst_count: got %0d want 0", count); end
    rst = 1'b0;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (push_ready !== 1'b1) begin n_errors++; $display("FAIL post_rst_ready: got %b want 1", push_ready); end
    tick();
    n_checks++; if (count !== 4'd0 || pop_valid !== 2'b00) begin
      n_errors++; $display("FAIL idle: count %0d valid %b want 0 00", count, pop_valid); end
  endtask

  task automatic test_fill();
    logic [31:0] a;
    for (int b = 0; b < 4; b++) begin
      a = 32'h1000 + 32'(8 * b);
      drive(0, 0, 2'b11, a, I_ADDU, a + 4, I_ADDU, 0);
      tick();
      n_checks++; if (count !== CW'(2 * (b + 1))) begin
        n_errors++; $display("FAIL fill_count%0d: got %0d want %0d", b, count, 2 * (b + 1)); end
    end
    n_checks++; if (push_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %b want 0", push_ready); end
    drive(0, 0, 2'b11, 32'h1020, I_ADDU, 32'h1024, I_ADDU, 1);
    tick();
    n_checks++; if (count !== 4'd7 || push_ready !== 1'b0) begin
      n_errors++; $display("FAIL cnt7: count %0d ready %b want 7 0", count, push_ready); end
    n_checks++; if (pop_pc[31:0] !== 32'h1004) begin n_errors++; $display("FAIL cnt7_pc: got %h want 1004", pop_pc[31:0]); end
    tick();
    n_checks++; if (count !== 4'd6 || push_ready !== 1'b1) begin
      n_errors++; $display("FAIL cnt6: count %0d ready %b want 6 1", count, push_ready); end
    drive(0, 0, 2'b11, 32'h1020, I_ADDU, 32'h1024, I_ADDU, 0);
    tick();
    n_checks++; if (count !== 4'd8) begin n_errors++; $display("FAIL held_beat: count %0d want 8", count); end
    drive(0, 0, 2'b00, 0, 0, 0, 0, 2);
    for (int b = 0; b < 4; b++) begin
      a = 32'h1008 + 32'(8 * b);
      n_checks++; if (pop_pc !== {a + 32'd4, a} || pop_valid !== 2'b11) begin
        n_errors++; $display("FAIL drain%0d: pc %h valid %b want %h_%h 11", b, pop_pc, pop_valid, a + 4, a); end
      tick();
    end
  endtask

  task automatic test_delay_slot();
    drive(0, 0, 2'b11, 32'h100, I_BEQ, 32'h104, I_ADDU, 0);
    tick();
    n_checks++; if (pop_inslot !== 2'b10 || pop_pc !== {32'h104, 32'h100}) begin
      n_errors++; $display("FAIL slot_beq: inslot %b pc %h want 10 104_100", pop_inslot, pop_pc); end
    drive(0, 0, 2'b11, 32'h108, I_ADDU, 32'h10c, I_J, 2);
    tick();
    n_checks++; if (pop_inslot !== 2'b00 || count !== 4'd2) begin
      n_errors++; $display("FAIL slot_j: inslot %b count %0d want 00 2", pop_inslot, count); end
    drive(0, 0, 2'b11, 32'h110, I_ADDU, 32'h114, I_ADDU, 2);
    tick();
    n_checks++; if (pop_inslot !== 2'b01 || pop_pc[31:0] !== 32'h110) begin
      n_errors++; $display("FAIL slot_lastbr: inslot %b pc %h want 01 110", pop_inslot, pop_pc[31:0]); end
    drive(0, 0, 2'b00, 0, 0, 0, 0, 2);
    tick();
  endtask

  task automatic test_br_keep_slot();
    drive(0, 0, 2'b11, 32'h200, I_BEQ, 32'h204, I_ADDU, 0); tick();
    drive(0, 0, 2'b11, 32'h208, I_ADDU, 32'h20c, I_ADDU, 0); tick();
    drive(0, 0, 2'b11, 32'h210, I_ADDU, 32'h214, I_ADDU, 0); tick();
    drive(0, 1, 2'b11, 32'h300, I_ADDU, 32'h304, I_ADDU, 1);
    tick();
    n_checks++; if (count !== 4'd1 || pop_valid !== 2'b01) begin
      n_errors++; $display("FAIL keep_count: count %0d valid %b want 1 01", count, pop_valid); end
    n_checks++; if (pop_pc[31:0] !== 32'h204 || pop_inslot[0] !== 1'b1) begin
      n_errors++; $display("FAIL keep_slot: pc %h inslot %b want 204 1", pop_pc[31:0], pop_inslot[0]); end
    drive(0, 0, 2'b11, 32'h400, I_ADDU, 32'h404, I_ADDU, 1);
    tick();
    n_checks++; if (count !== 4'd2 || pop_pc[31:0] !== 32'h400 || pop_inslot !== 2'b00) begin
      n_errors++; $display("FAIL keep_after: count %0d pc %h inslot %b want 2 400 00", count, pop_pc[31:0], pop_inslot); end
    drive(0, 0, 2'b00, 0, 0, 0, 0, 2);
    tick();
  endtask

  task automatic test_br_wait_slot();
    drive(0, 0, 2'b01, 32'h300, I_JAL, 0, 0, 0); tick();
    drive(0, 1, 2'b00, 0, 0, 0, 0, 1); tick();
    n_checks++; if (count !== 4'd0 || pop_valid !== 2'b00) begin
      n_errors++; $display("FAIL wait_empty: count %0d valid %b want 0 00", count, pop_valid); end
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 2'b11, 32'h304, I_ADDU, 32'h308, I_ADDU, 0); tick();
    n_checks++; if (count !== 4'd1 || pop_pc[31:0] !== 32'h304 || pop_inslot[0] !== 1'b1) begin
      n_errors++; $display("FAIL wait_slot: count %0d pc %h inslot %b want 1 304 1", count, pop_pc[31:0], pop_inslot[0]); end
    drive(0, 0, 2'b11, 32'h500, I_ADDU, 32'h504, I_ADDU, 1); tick();
    n_checks++; if (count !== 4'd2 || pop_pc[31:0] !== 32'h500 || pop_inslot[0] !== 1'b0) begin
      n_errors++; $display("FAIL wait_after: count %0d pc %h inslot %b want 2 500 0", count, pop_pc[31:0], pop_inslot[0]); end
    drive(0, 0, 2'b00, 0, 0, 0, 0, 2); tick();
    drive(0, 0, 2'b01, 32'h600, I_BEQ, 0, 0, 0); tick();
    drive(0, 1, 2'b11, 32'h604, I_ADDU, 32'h608, I_ADDU, 1); tick();
    n_checks++; if (count !== 4'd1 || pop_pc[31:0] !== 32'h604 || pop_inslot[0] !== 1'b1) begin
      n_errors++; $display("FAIL slot_same_cycle: count %0d pc %h inslot %b want 1 604 1", count, pop_pc[31:0], pop_inslot[0]); end
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1); tick();
  endtask

  task automatic test_random();
    logic [31:0] npc;
    logic [1:0]  pv;
    int          pc;
    bit          f, b;
    bit          ev;
    npc = 32'h0001_0000;
    for (int c = 0; c < 200; c++) begin
      pc = $urandom_range(0, POP_W);
      case ($urandom_range(0, 2))
        0: pv = 2'b00;
        1: pv = 2'b01;
        default: pv = 2'b11;
      endcase
      f = ($urandom_range(0, 39) == 0);
      b = (mq.size() >= 1) && (pc >= 1) && ($urandom_range(0, 7) == 0);
      drive(f, b, pv, npc, rand_inst(), npc + 4, rand_inst(), pc);
      npc = npc + 8;
      tick();
      n_checks++; if (count !== CW'(mq.size())) begin
        n_errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, mq.size()); end
      n_checks++; if (push_ready !== ((DEPTH - mq.size()) >= PUSH_W)) begin
        n_errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, push_ready, (DEPTH - mq.size()) >= PUSH_W); end
      for (int k = 0; k < POP_W; k++) begin
        ev = mq.size() > k;
        n_checks++; if (pop_valid[k] !== ev) begin
          n_errors++; $display("FAIL rnd_valid c%0d l%0d: got %b want %b", c, k, pop_valid[k], ev); end
        if (ev) begin
          n_checks++;
          if (pop_pc[32*k +: 32] !== mq[k].pc || pop_inst[32*k +: 32] !== mq[k].inst ||
              pop_inslot[k] !== mq[k].inslot) begin
            n_errors++;
            $display("FAIL rnd_entry c%0d l%0d: got %h/%h/%b want %h/%h/%b", c, k,
                     pop_pc[32*k +: 32], pop_inst[32*k +: 32], pop_inslot[k],
                     mq[k].pc, mq[k].inst, mq[k].inslot);
          end
        end
      end
    end
  endtask

  task automatic test_flush();
    drive(0, 0, 2'b11, 32'h800, I_ADDU, 32'h804, I_J, 0); tick();
    drive(1, 0, 2'b11, 32'h808, I_ADDU, 32'h80c, I_ADDU, 0); tick();
    n_checks++; if (count !== 4'd0 || pop_valid !== 2'b00) begin
      n_errors++; $display("FAIL flush: count %0d valid %b want 0 00", count, pop_valid); end
    drive(0, 0, 2'b11, 32'h900, I_ADDU, 32'h904, I_ADDU, 0); tick();
    n_checks++; if (count !== 4'd2 || pop_pc[31:0] !== 32'h900 || pop_inslot !== 2'b00) begin
      n_errors++; $display("FAIL post_flush: count %0d pc %h inslot %b want 2 900 00", count, pop_pc[31:0], pop_inslot); end
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 2); tick();
    n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL pop_clamp: count %0d want 0", count); end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
    test_reset();
    test_fill();
    test_delay_slot();
    test_br_keep_slot();
    test_br_wait_slot();
    test_random();
    test_flush();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
